// File: rtl/core_pkg.sv
// Shared constants and FSM state type for the fetch program-counter unit.
package core_pkg;

    localparam int unsigned XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_1000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned PC_INC       = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/branch-unit to PC-unit bundle: redirect requests in, fetch PC and status out.
interface pc_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;
    logic             jump;
    logic [XLEN-1:0]  jump_target;
    logic             trap;
    logic             mret;
    logic [XLEN-1:0]  mepc;
    logic             halt_req;
    logic             resume;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic             pc_valid;
    logic             misaligned;
    logic [XLEN-1:0]  bad_addr;
    logic             halted;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output stall, br_taken, br_target, jump, jump_target,
               trap, mret, mepc, halt_req, resume,
        input  pc, pc_plus4, pc_valid, misaligned, bad_addr, halted, redirect_cnt
    );

    modport slave (
        input  stall, br_taken, br_target, jump, jump_target,
               trap, mret, mepc, halt_req, resume,
        output pc, pc_plus4, pc_valid, misaligned, bad_addr, halted, redirect_cnt
    );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux with jump/branch target alignment check.
module pc_next_sel #(
    parameter int unsigned    XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int unsigned    IALIGN      = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    input  logic            halt_req,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect,
    output logic            misaligned,
    output logic            halt_go,
    output logic [XLEN-1:0] target
);
    import core_pkg::*;

    logic tgt_bad;

    always_comb begin
        target     = jump ? jump_target : br_target;
        tgt_bad    = (IALIGN == 16) ? target[0] : (target[1:0] != 2'b00);
        next_pc    = pc + XLEN'(PC_INC);
        redirect   = 1'b0;
        misaligned = 1'b0;
        halt_go    = 1'b0;
        if (trap) begin
            next_pc  = TRAP_VECTOR;
            redirect = 1'b1;
        end else if (mret) begin
            next_pc  = mepc;
            redirect = 1'b1;
        end else if (stall) begin
            next_pc = pc;
        end else if (jump || br_taken) begin
            redirect = 1'b1;
            if (tgt_bad) begin
                next_pc    = TRAP_VECTOR;
                misaligned = 1'b1;
            end else begin
                next_pc = target;
            end
        end else if (halt_req) begin
            next_pc = pc;
            halt_go = 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: BOOT/RUN/HALT control, PC register, misalignment capture
// and a saturating count of non-sequential updates.
module pc_unit #(
    parameter int unsigned     XLEN         = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(core_pkg::RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(core_pkg::TRAP_VECTOR),
    parameter int unsigned     IALIGN       = 32,
    parameter int unsigned     CNT_W        = 16
) (
    input logic     clk,
    input logic     rst,
    pc_unit_if.slave bus
);
    import core_pkg::*;

    pc_state_t        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d, next_pc, target, bad_q;
    logic             valid_q, mis_q, halted_q;
    logic             redirect, mis_sel, halt_go;
    logic [CNT_W-1:0] cnt_q;
    logic             run;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .IALIGN      (IALIGN)
    ) u_next_sel (
        .pc          (pc_q),
        .stall       (bus.stall),
        .br_taken    (bus.br_taken),
        .br_target   (bus.br_target),
        .jump        (bus.jump),
        .jump_target (bus.jump_target),
        .trap        (bus.trap),
        .mret        (bus.mret),
        .mepc        (bus.mepc),
        .halt_req    (bus.halt_req),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .misaligned  (mis_sel),
        .halt_go     (halt_go),
        .target      (target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        run     = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                run  = 1'b1;
                pc_d = next_pc;
                if (halt_go) state_d = HALT;
            end
            HALT: if (bus.resume) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Status flags are registered from the next state so they line up with pc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_VECTOR;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
            bad_q    <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            valid_q  <= (state_d == RUN);
            halted_q <= (state_d == HALT);
            mis_q    <= run && mis_sel;
            if (run && mis_sel) bad_q <= target;
            if (run && redirect && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_q + XLEN'(PC_INC);
    assign bus.pc_valid     = valid_q;
    assign bus.misaligned   = mis_q;
    assign bus.bad_addr     = bad_q;
    assign bus.halted       = halted_q;
    assign bus.redirect_cnt = cnt_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the fixed 32-bit PC register.
- Holds the fetch PC and selects the next PC from sequential, branch, jump, trap and mret sources.
- Adds stall, halt/resume, misaligned-target trapping and a saturating redirect counter.
- Sits between the control/branch unit and the instruction-memory address port of the single-cycle core.

Parameters:
- XLEN, 32, PC/data width in bits.
- RESET_VECTOR, 32'h0000_1000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a trap or a misaligned target.
- IALIGN, 32, instruction alignment in bits: 32 checks target[1:0], 16 checks target[0].
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC; suppresses branch, jump and sequential update.
- br_taken  in  1  conditional branch taken this cycle.
- br_target  in  XLEN  branch target.
- jump  in  1  JAL/JALR this cycle.
- jump_target  in  XLEN  jump target.
- trap  in  1  synchronous exception/ecall.
- mret  in  1  return from trap.
- mepc  in  XLEN  return address for mret.
- halt_req  in  1  request halt (ebreak/debug).
- resume  in  1  leave the halt state.
- pc  out  XLEN  current fetch PC.
- pc_plus4  out  XLEN  pc+4, combinational.
- pc_valid  out  1  pc is a valid fetch address.
- misaligned  out  1  one-cycle pulse: the selected target was misaligned.
- bad_addr  out  XLEN  last misaligned target.
- halted  out  1  FSM is in HALT.
- redirect_cnt  out  CNT_W  saturating count of non-sequential PC updates.

Behaviour:
- Reset (asynchronous, active-high; applies immediately, including mid-operation):
  - pc = RESET_VECTOR, state = BOOT, pc_valid = 0, misaligned = 0, bad_addr = 0, halted = 0, redirect_cnt = 0.
- FSM states: BOOT, RUN, HALT.
  - BOOT: pc holds RESET_VECTOR, pc_valid = 0; unconditionally goes to RUN next edge. All inputs are ignored in BOOT.
  - RUN: pc_valid = 1; the PC updates every edge per the priority list below.
  - HALT: pc_valid = 0, halted = 1, pc holds. resume -> RUN next edge with pc unchanged. trap, mret, branch and jump are ignored in HALT.
- RUN next-PC priority, highest first:
  1. trap: pc = TRAP_VECTOR; overrides stall.
  2. mret: pc = mepc; overrides stall; mepc is not alignment-checked.
  3. stall: pc holds; jump, branch and halt_req are ignored (the requester re-presents them).
  4. jump: pc = jump_target.
  5. br_taken: pc = br_target.
  6. halt_req: pc holds; state goes to HALT.
  7. otherwise: pc = pc+4, wrapping modulo 2^XLEN (0xFFFF_FFFC -> 0x0).
- Misaligned target (jump or branch target fails the IALIGN check):
  - pc = TRAP_VECTOR.
  - misaligned = 1 for exactly the following cycle.
  - bad_addr is loaded with the target and held until the next misalignment or reset.
- Simultaneous halt_req with jump/branch: the redirect completes this edge; halt_req is honoured only when it wins the priority list on a later edge.
- redirect_cnt increments by 1 on every RUN edge that takes priority 1, 2, 4 or 5 (misaligned cases included). It saturates at all-ones and never wraps.
- pc_plus4 = pc + 4, truncated to XLEN bits.
- Latency: all sources take effect on pc one edge after being sampled. No combinational path from any input to pc.

Decomposition:
- Shared package (core_pkg): XLEN, RESET_VECTOR, TRAP_VECTOR, the FSM state typedef (pc_state_t: BOOT/RUN/HALT), and the instruction increment constant 4.
- One natural sub-module: pc_next_sel, the combinational priority mux plus alignment check. It outputs the next pc, a redirect flag and a misaligned flag.
- The FSM, PC register and counter stay in pc_unit.

Test Plan:
- Reset then release: pc = 0x1000, pc_valid = 0 for one cycle; then 0x1000 valid, then 0x1004, 0x1008. Assert rst mid-run at pc = 0x1010 -> immediate pc = 0x1000, redirect_cnt = 0.
- jump_target = 0x2000 together with br_taken/br_target = 0x3000 -> pc = 0x2000 next edge, redirect_cnt +1. With stall = 1 and jump -> pc holds, count unchanged.
- Misaligned jump_target = 0x2002 with IALIGN = 32 -> pc = 0x100, misaligned pulses exactly one cycle, bad_addr = 0x2002. Repeat with IALIGN = 16 -> pc = 0x2002, no pulse.
- trap with stall = 1 -> pc = 0x100. Then mret with mepc = 0x1234 -> pc = 0x1234. redirect_cnt +2.
- halt_req at pc = 0x1008 -> halted = 1, pc_valid = 0, pc holds 0x1008 for 5 cycles while trap is pulsed (ignored). resume -> pc 0x1008 valid, then 0x100C.
- Wrap and saturation: force pc to 0xFFFF_FFFC -> next pc = 0x0. With CNT_W = 2, four redirects -> redirect_cnt = 3 and stays at 3.
